// File: rtl/railway_pkg.sv
// Shared constants for the train presence detector: FSM state encoding,
// default parameter values and a width helper.
package railway_pkg;

  localparam int unsigned DEB_CYCLES_DEF     = 4;
  localparam int unsigned CNT_W_DEF          = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000;

  localparam logic [1:0] ST_CLEAR    = 2'd0;
  localparam logic [1:0] ST_OCCUPIED = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  // Bits needed to hold the value n (at least 1).
  function automatic int unsigned width_for(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Axle sensor front end: 2-flop synchronizer, stable-sample debouncer and
// one-cycle rising-edge pulse of the debounced level.
module sensor_debounce
  import railway_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic rise
);

  localparam int unsigned ARM_CYCLES = DEB_CYCLES + 2;
  localparam int unsigned SW         = width_for(ARM_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          armed;
  logic          level;
  logic          level_q;
  logic [SW-1:0] stable_cnt;

  // Until armed, the input must be seen low long enough to flush the reset
  // zeros out of the synchronizer, so a wheel held across reset is ignored.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      armed      <= 1'b0;
      level      <= 1'b0;
      level_q    <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      if (!armed) begin
        if (sync2) begin
          stable_cnt <= '0;
        end else if (stable_cnt == SW'(ARM_CYCLES - 1)) begin
          armed      <= 1'b1;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + SW'(1);
        end
      end else if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == SW'(DEB_CYCLES - 1)) begin
        level      <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + SW'(1);
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/train_presence_detector.sv
// Track-section occupancy detector: counts axles in/out and drives x.
// Optional occupancy watchdog enabled by macro OCCUPANCY_TIMEOUT_EN.
module train_presence_detector
  import railway_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             entry_raw,
  input  logic             exit_raw,
  output logic             x,
  output logic [CNT_W-1:0] axle_count,
  output logic             fault
);

  logic             entry_ev;
  logic             exit_ev;
  logic             inc;
  logic             dec;
  logic             ovf;
  logic             unf;
  logic             timeout;
  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [CNT_W-1:0] cnt_n;

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_entry (
    .clk  (clk),
    .clr  (clr),
    .raw  (entry_raw),
    .rise (entry_ev)
  );

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_exit (
    .clk  (clk),
    .clr  (clr),
    .raw  (exit_raw),
    .rise (exit_ev)
  );

`ifdef OCCUPANCY_TIMEOUT_EN
  localparam int unsigned WD_W = width_for(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wd_cnt <= '0;
    end else if (state != ST_OCCUPIED || entry_ev || exit_ev) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign timeout = (state == ST_OCCUPIED) && !(entry_ev || exit_ev) &&
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    inc   = entry_ev & ~exit_ev;
    dec   = exit_ev & ~entry_ev;
    ovf   = inc & (axle_count == '1);
    unf   = dec & (axle_count == '0);
    cnt_n = axle_count;
    if (inc && !ovf) begin
      cnt_n = axle_count + CNT_W'(1);
    end else if (dec && !unf) begin
      cnt_n = axle_count - CNT_W'(1);
    end

    state_n = state;
    case (state)
      ST_CLEAR:    if (cnt_n != '0) state_n = ST_OCCUPIED;
      ST_OCCUPIED: if (cnt_n == '0) state_n = ST_CLEAR;
      default:     state_n = ST_FAULT;
    endcase
    if (ovf || unf || timeout) begin
      state_n = ST_FAULT;
    end
  end

  // Outputs are registered from the next state so x tracks the count change.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= ST_CLEAR;
      axle_count <= '0;
      x          <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      axle_count <= cnt_n;
      x          <= (state_n != ST_CLEAR);
      fault      <= (state_n == ST_FAULT);
    end
  end

endmodule
